serial_adder: RTL and testbench

Parametrised bit-serial adder: the sequential successor of our single-bit full adder. It adds two WIDTH-bit operands plus a carry-in by reusing one full-adder cell for WIDTH clock cycles, LSB first, under a start/done handshake. It sits beside the combinational arithmetic blocks as the area-cheap adder for wide operands where latency is acceptable.

---
 rtl/serial_adder.sv | 95 +++++++++
 tb/tb_serial_adder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell reused for WIDTH cycles, LSB first,
// with a start/done handshake and registered sum/carry/overflow.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; result registers hold the last result
// RUN   | one operand bit processed per edge until bit WIDTH-1 is done
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic [CNT_W-1:0] cnt;
  logic             c;

  logic             s_bit;
  logic             c_nxt;
  logic [WIDTH-1:0] psum_nxt;

  always_comb begin
    s_bit    = a_sh[0] ^ b_sh[0] ^ c;
    c_nxt    = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
    // new bit enters from the MSB end so the LSB lands at bit 0 after WIDTH shifts
    psum_nxt = psum >> 1;
    psum_nxt[WIDTH-1] = s_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      psum     <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            c     <= ci;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          c    <= c_nxt;
          psum <= psum_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // c is still the carry into the MSB on this edge
            sum      <= psum_nxt;
            carry    <= c_nxt;
            overflow <= c ^ c_nxt;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH 1, 8 and 16.
module tb_serial_adder;

  typedef struct {
    logic [63:0] sum;
    logic        carry;
    logic        ovf;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  logic       start1 = 1'b0, ci1 = 1'b0, busy1, done1, carry1, ovf1;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic       start8 = 1'b0, ci8 = 1'b0, busy8, done8, carry8, ovf8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic        start16 = 1'b0, ci16 = 1'b0, busy16, done16, carry16, ovf16;
  logic [15:0] a16 = '0, b16 = '0, sum16;

  exp_t q1[$], q8[$], q16[$];
  logic [63:0] hold1 = '0, hold8 = '0, hold16 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .ci(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1), .overflow(ovf1));
  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .ci(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .overflow(ovf8));
  serial_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .ci(ci16),
    .busy(busy16), .done(done16), .sum(sum16), .carry(carry16), .overflow(ovf16));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input int due);
    exp_t        e;
    logic [63:0] m;
    logic [64:0] full;
    m     = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    full  = {1'b0, a & m} + {1'b0, b & m} + 65'(ci);
    e.sum   = full[63:0] & m;
    e.carry = full[w];
    e.ovf   = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
    e.due   = due;
    return e;
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      1:       return busy1;
      8:       return busy8;
      default: return busy16;
    endcase
  endfunction

  // Scoreboard side: pop and compare on every done pulse
  always @(negedge clk) begin
    exp_t e;
    check("busy_and_done", {61'd0, busy1 & done1, busy8 & done8, busy16 & done16}, 64'd0);
    if (!rst) begin
      if (busy1)  check("w1_sum_hold",  64'(sum1),  hold1);
      if (busy8)  check("w8_sum_hold",  64'(sum8),  hold8);
      if (busy16) check("w16_sum_hold", 64'(sum16), hold16);
      if (done1) begin
        if (q1.size() == 0) check("w1_spurious_done", 64'd1, 64'd0);
        else begin
          e = q1.pop_front();
          check("w1_sum", 64'(sum1), e.sum);
          check("w1_carry", 64'(carry1), 64'(e.carry));
          check("w1_ovf", 64'(ovf1), 64'(e.ovf));
          check("w1_latency", 64'(cyc), 64'(e.due));
          hold1 = e.sum;
        end
      end
      if (done8) begin
        if (q8.size() == 0) check("w8_spurious_done", 64'd1, 64'd0);
        else begin
          e = q8.pop_front();
          check("w8_sum", 64'(sum8), e.sum);
          check("w8_carry", 64'(carry8), 64'(e.carry));
          check("w8_ovf", 64'(ovf8), 64'(e.ovf));
          check("w8_latency", 64'(cyc), 64'(e.due));
          hold8 = e.sum;
        end
      end
      if (done16) begin
        if (q16.size() == 0) check("w16_spurious_done", 64'd1, 64'd0);
        else begin
          e = q16.pop_front();
          check("w16_sum", 64'(sum16), e.sum);
          check("w16_carry", 64'(carry16), 64'(e.carry));
          check("w16_ovf", 64'(ovf16), 64'(e.ovf));
          check("w16_latency", 64'(cyc), 64'(e.due));
          hold16 = e.sum;
        end
      end
    end
  end

  task automatic issue(input int w, input logic [63:0] a, input logic [63:0] b, input logic ci);
    int n = 0;
    while (busy_of(w) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("issue_timeout", 64'd1, 64'd0);
    case (w)
      1: begin
        a1 = a[0:0]; b1 = b[0:0]; ci1 = ci; start1 = 1'b1;
        q1.push_back(model(1, a, b, ci, cyc + 2));
      end
      8: begin
        a8 = a[7:0]; b8 = b[7:0]; ci8 = ci; start8 = 1'b1;
        q8.push_back(model(8, a, b, ci, cyc + 9));
      end
      default: begin
        a16 = a[15:0]; b16 = b[15:0]; ci16 = ci; start16 = 1'b1;
        q16.push_back(model(16, a, b, ci, cyc + 17));
      end
    endcase
    @(negedge clk);
    start1 = 1'b0;
    start8 = 1'b0;
    start16 = 1'b0;
    a8 = $urandom; b8 = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q1.size() + q8.size() + q16.size()) != 0; i++)
      @(negedge clk);
    check("drain_q1", 64'(q1.size()), 64'd0);
    check("drain_q8", 64'(q8.size()), 64'd0);
    check("drain_q16", 64'(q16.size()), 64'd0);
  endtask

  initial begin
    logic [15:0] ops16 [3][2];
    int last_acc;
    ops16[0][0] = 16'hFFFF; ops16[0][1] = 16'hFFFF;
    ops16[1][0] = 16'h7FFF; ops16[1][1] = 16'h0001;
    ops16[2][0] = 16'h1234; ops16[2][1] = 16'h4321;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_sum", 64'(sum8), 64'd0);
    check("rst_carry", 64'(carry8), 64'd0);
    check("rst_ovf", 64'(ovf8), 64'd0);
    check("rst_sum16", 64'(sum16), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      issue(1, 64'(i[2]), 64'(i[1]), i[0]);
    drain();

    issue(8, 64'hFF, 64'h01, 1'b0);
    issue(8, 64'h7F, 64'h00, 1'b1);
    issue(8, 64'h80, 64'h80, 1'b0);
    drain();

    // start while busy must be ignored
    issue(8, 64'h12, 64'h34, 1'b0);
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    drain();

    // reset mid-RUN aborts without a done pulse
    issue(8, 64'hFF, 64'hFF, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    void'(q8.pop_back());
    @(negedge clk);
    rst = 1'b0;
    hold1 = '0; hold8 = '0; hold16 = '0;
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_done", 64'(done8), 64'd0);
    check("abort_sum", 64'(sum8), 64'd0);
    check("abort_carry", 64'(carry8), 64'd0);
    check("abort_ovf", 64'(ovf8), 64'd0);
    repeat (12) @(negedge clk);
    issue(8, 64'hA5, 64'h5A, 1'b1);
    drain();

    // start held high: a new op is accepted in every done cycle
    last_acc = 0;
    ci16 = 1'b1;
    start16 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      while (busy16 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) check("w16_accept_timeout", 64'd1, 64'd0);
      a16 = ops16[k][0];
      b16 = ops16[k][1];
      ci16 = (k == 0);
      q16.push_back(model(16, 64'(a16), 64'(b16), ci16, cyc + 17));
      if (k > 0) check("w16_period", 64'(cyc - last_acc), 64'd17);
      last_acc = cyc;
      @(negedge clk);
    end
    @(negedge clk);
    start16 = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
